instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter Psize, default 6, giving the program counter and program address width in bits.
REQ-002 The block SHALL have parameter Isize, default 20, giving the instruction word width in bits; opcode is bits [Isize-1:Isize-6].
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port run, input, 1 bit: start fetching from IDLE or resume from HALT.
REQ-006 The block SHALL have port prog_addr, output, Psize bits: program memory address, always equal to the PC.
REQ-007 The block SHALL have port prog_rd, output, 1 bit: program memory read request.
REQ-008 The block SHALL have port prog_ack, input, 1 bit: program memory read data valid.
REQ-009 The block SHALL have port prog_data, input, Isize bits: program memory read data.
REQ-010 The block SHALL have port instr, output, Isize bits: registered instruction presented to the decoder.
REQ-011 The block SHALL have port opcode, output, 6 bits: top 6 bits of instr.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: instr holds an unconsumed instruction.
REQ-013 The block SHALL have port instr_ready, input, 1 bit: decoder/execute accepts instr this cycle.
REQ-014 The block SHALL have port PCincr, input, 1 bit: decoder request to advance PC by 1 for the accepted instruction.
REQ-015 The block SHALL have port branch_rel, input, 1 bit: decoder request to add a signed offset to the PC.
REQ-016 The block SHALL have port branch_abs, input, 1 bit: decoder request to load an absolute target into the PC.
REQ-017 The block SHALL have port branch_addr, input, Psize bits: absolute target, or two's-complement offset for branch_rel.
REQ-018 The block SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, FETCH, ISSUE, HALT.
REQ-020 In IDLE, run=1 SHALL cause a transition to FETCH on the next edge; otherwise the FSM SHALL remain in IDLE.
REQ-021 In FETCH, prog_rd SHALL be 1; prog_rd SHALL be 0 in every other state.
REQ-022 In FETCH with prog_ack=1, instr SHALL capture prog_data, instr_valid SHALL be set, and the FSM SHALL enter ISSUE on the same edge; the minimum fetch latency is 1 cycle from prog_rd to instr_valid.
REQ-023 prog_ack received outside FETCH SHALL be ignored, with no change to instr.
REQ-024 In ISSUE, instr, opcode and instr_valid SHALL remain stable until instr_ready=1.
REQ-025 On the ISSUE edge with instr_ready=1, PC update priority SHALL be: branch_abs -> PC=branch_addr; else branch_rel -> PC=PC+branch_addr, modulo 2^Psize; else PCincr -> PC=PC+1, modulo 2^Psize; else PC unchanged.
REQ-026 PC+1 at PC=2^Psize-1 SHALL wrap to 0, and relative branches SHALL wrap likewise with no flag.
REQ-027 On acceptance, instr_valid SHALL clear; the FSM SHALL enter HALT if none of branch_abs, branch_rel or PCincr is set, otherwise FETCH.
REQ-028 Control inputs PCincr, branch_rel, branch_abs and branch_addr SHALL be sampled only on the accepting edge.
REQ-029 In HALT, halted SHALL be 1 and PC SHALL hold; run=1 SHALL set PC=PC+1 (wrapping) and enter FETCH.
REQ-030 run SHALL be ignored in FETCH and ISSUE.
REQ-031 opcode SHALL be combinationally equal to instr[Isize-1:Isize-6].

Reset
REQ-032 reset=1 SHALL immediately, without a clock, force state=IDLE, PC=0, instr=0, instr_valid=0, prog_rd=0, halted=0.
REQ-033 Reset asserted mid-fetch or mid-issue SHALL abandon the transaction; a late prog_ack after reset release SHALL be ignored.
REQ-034 After reset release, no fetch SHALL occur until run=1.

Verification
REQ-035 Sequential fetch: reset, run pulse, memory acks with 1-cycle latency, PCincr=1 always -> prog_addr steps 0,1,2,3; instr_valid once per instruction.
REQ-036 Backpressure: hold instr_ready=0 for 5 cycles -> instr stable, prog_rd=0, PC unchanged until the accept edge.
REQ-037 Branches: at PC=4, branch_rel=1 with branch_addr=6'b111110 -> next prog_addr=2; at PC=2, branch_abs=1 and branch_rel=1 with branch_addr=9 -> next prog_addr=9, abs wins.
REQ-038 Wrap: Psize=6, PC=63, PCincr=1 -> next prog_addr=0.
REQ-039 Halt: accept with PCincr=0 and no branch at PC=7 -> halted=1, prog_rd=0; run pulse -> prog_addr=8, FETCH.
REQ-040 Async reset during FETCH with 3-cycle ack delay -> outputs zero before the next edge; the delayed prog_ack is ignored, instr_valid stays 0.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch unit. Reads one instruction word from
//                program memory, holds it for the decoder until it is
//                accepted, then updates the PC (increment, relative branch,
//                absolute branch) or halts when the decoder asks for
//                nothing.
//  Ports       : clk, reset            - clock, async active-high reset
//                run                   - start from IDLE / resume from HALT
//                prog_addr/rd/ack/data - program memory read port
//                instr, opcode         - instruction to decoder (+ top 6 bits)
//                instr_valid/ready     - decoder handshake
//                PCincr, branch_rel,
//                branch_abs, branch_addr - PC update request on accept
//                halted                - high while in HALT
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int Psize = 6,
    parameter int Isize = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic [Psize-1:0] prog_addr,
    output logic             prog_rd,
    input  logic             prog_ack,
    input  logic [Isize-1:0] prog_data,
    output logic [Isize-1:0] instr,
    output logic [5:0]       opcode,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             PCincr,
    input  logic             branch_rel,
    input  logic             branch_abs,
    input  logic [Psize-1:0] branch_addr,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t           r_state;
    logic [Psize-1:0] r_pc;
    logic [Isize-1:0] r_instr;
    logic             r_instr_valid;
    logic             r_prog_rd;
    logic             r_halted;

    logic [Psize-1:0] w_pc_accept;
    logic             w_pc_change;

    // PC value applied on the accepting edge. Additions truncate to Psize,
    // so wrap-around is implicit and raises no flag.
    always_comb begin
        w_pc_accept = r_pc;
        w_pc_change = branch_abs | branch_rel | PCincr;
        if (branch_abs) begin
            w_pc_accept = branch_addr;
        end else if (branch_rel) begin
            w_pc_accept = r_pc + branch_addr;
        end else if (PCincr) begin
            w_pc_accept = r_pc + Psize'(1);
        end
    end

    // prog_rd and halted are registered alongside the state so they always
    // reflect the state being entered (prog_rd == FETCH, halted == HALT).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_prog_rd     <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state   <= ST_FETCH;
                        r_prog_rd <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (prog_ack) begin
                        r_instr       <= prog_data;
                        r_instr_valid <= 1'b1;
                        r_prog_rd     <= 1'b0;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_pc          <= w_pc_accept;
                        if (w_pc_change) begin
                            r_state   <= ST_FETCH;
                            r_prog_rd <= 1'b1;
                        end else begin
                            r_state   <= ST_HALT;
                            r_halted  <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    // Resume continues with the instruction after the one
                    // that caused the halt.
                    if (run) begin
                        r_pc      <= r_pc + Psize'(1);
                        r_halted  <= 1'b0;
                        r_prog_rd <= 1'b1;
                        r_state   <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign prog_addr   = r_pc;
    assign prog_rd     = r_prog_rd;
    assign instr       = r_instr;
    assign opcode      = r_instr[Isize-1:Isize-6];
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch (Psize=6,
//                Isize=20). Program memory contents come from mem_word().
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int PSIZE = 6;
    localparam int ISIZE = 20;

    logic             clk;
    logic             reset;
    logic             run;
    logic [PSIZE-1:0] prog_addr;
    logic             prog_rd;
    logic             prog_ack;
    logic [ISIZE-1:0] prog_data;
    logic [ISIZE-1:0] instr;
    logic [5:0]       opcode;
    logic             instr_valid;
    logic             instr_ready;
    logic             PCincr;
    logic             branch_rel;
    logic             branch_abs;
    logic [PSIZE-1:0] branch_addr;
    logic             halted;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch #(.Psize(PSIZE), .Isize(ISIZE)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .prog_addr   (prog_addr),
        .prog_rd     (prog_rd),
        .prog_ack    (prog_ack),
        .prog_data   (prog_data),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PCincr      (PCincr),
        .branch_rel  (branch_rel),
        .branch_abs  (branch_abs),
        .branch_addr (branch_addr),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory image: opcode field is addr ^ 0x15.
    function automatic logic [ISIZE-1:0] mem_word(input logic [PSIZE-1:0] a);
        logic [7:0] mid;
        mid = 8'(a) * 8'd7 + 8'd1;
        return {a ^ 6'h15, mid, ~a};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect the DUT in FETCH at exp_addr; ack after lat cycles with prog_rd.
    task automatic do_fetch(input int lat, input logic [PSIZE-1:0] exp_addr);
        check("fetch_rd", 32'(prog_rd), 32'd1);
        check("fetch_addr", 32'(prog_addr), 32'(exp_addr));
        for (int i = 1; i < lat; i++) begin
            tick();
            check("fetch_wait_valid", 32'(instr_valid), 32'd0);
        end
        prog_ack  = 1'b1;
        prog_data = mem_word(prog_addr);
        tick();
        prog_ack  = 1'b0;
        prog_data = 20'hABCDE;
        check("issue_valid", 32'(instr_valid), 32'd1);
        check("issue_rd", 32'(prog_rd), 32'd0);
        check("issue_instr", 32'(instr), 32'(mem_word(exp_addr)));
        check("issue_opcode", 32'(opcode), 32'(exp_addr ^ 6'h15));
    endtask

    task automatic do_accept(input logic incr, input logic rel, input logic abs_b,
                             input logic [PSIZE-1:0] baddr);
        instr_ready = 1'b1;
        PCincr      = incr;
        branch_rel  = rel;
        branch_abs  = abs_b;
        branch_addr = baddr;
        tick();
        instr_ready = 1'b0;
        PCincr      = 1'b0;
        branch_rel  = 1'b0;
        branch_abs  = 1'b0;
        branch_addr = '0;
        check("accept_valid_clr", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        prog_ack    = 1'b0;
        prog_data   = '0;
        instr_ready = 1'b0;
        PCincr      = 1'b0;
        branch_rel  = 1'b0;
        branch_abs  = 1'b0;
        branch_addr = '0;
        #2;
        check("rst_addr", 32'(prog_addr), 32'd0);
        check("rst_rd", 32'(prog_rd), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        tick();
        reset = 1'b0;

        // IDLE: no fetch without run; stray ack ignored.
        tick();
        prog_ack  = 1'b1;
        prog_data = 20'h12345;
        tick();
        prog_ack  = 1'b0;
        check("idle_rd", 32'(prog_rd), 32'd0);
        check("idle_stray_ack_instr", 32'(instr), 32'd0);
        check("idle_stray_ack_valid", 32'(instr_valid), 32'd0);

        run = 1'b1;
        tick();
        run = 1'b0;

        // Sequential fetch 0..3.
        for (int a = 0; a < 4; a++) begin
            do_fetch(1, PSIZE'(a));
            do_accept(1'b1, 1'b0, 1'b0, '0);
        end

        // Backpressure at PC=4; junk controls and run while not ready.
        do_fetch(1, 6'd4);
        branch_abs  = 1'b1;
        branch_addr = 6'd33;
        run         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_instr", 32'(instr), 32'(mem_word(6'd4)));
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_rd", 32'(prog_rd), 32'd0);
            check("bp_addr", 32'(prog_addr), 32'd4);
        end
        branch_abs  = 1'b0;
        branch_addr = '0;
        run         = 1'b0;

        // Relative branch -2 from 4 -> 2.
        do_accept(1'b0, 1'b1, 1'b0, 6'b111110);
        do_fetch(1, 6'd2);
        // abs beats rel.
        do_accept(1'b1, 1'b1, 1'b1, 6'd9);
        do_fetch(2, 6'd9);
        do_accept(1'b0, 1'b0, 1'b1, 6'd63);
        do_fetch(1, 6'd63);
        // Increment wraps 63 -> 0.
        do_accept(1'b1, 1'b0, 1'b0, '0);
        do_fetch(1, 6'd0);
        do_accept(1'b0, 1'b0, 1'b1, 6'd7);
        do_fetch(1, 6'd7);

        // Halt at 7, then resume at 8.
        do_accept(1'b0, 1'b0, 1'b0, '0);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_rd", 32'(prog_rd), 32'd0);
        check("halt_addr", 32'(prog_addr), 32'd7);
        tick();
        check("halt_hold_addr", 32'(prog_addr), 32'd7);
        check("halt_hold_flag", 32'(halted), 32'd1);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("resume_halted", 32'(halted), 32'd0);
        do_fetch(1, 6'd8);

        // Relative wrap 8 + 60 -> 4.
        do_accept(1'b0, 1'b1, 1'b0, 6'd60);
        check("relwrap_addr", 32'(prog_addr), 32'd4);
        check("relwrap_rd", 32'(prog_rd), 32'd1);

        // Async reset mid-fetch, ack would have come 3 cycles in.
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_addr", 32'(prog_addr), 32'd0);
        check("async_rst_rd", 32'(prog_rd), 32'd0);
        check("async_rst_instr", 32'(instr), 32'd0);
        check("async_rst_valid", 32'(instr_valid), 32'd0);
        check("async_rst_halted", 32'(halted), 32'd0);
        #1;
        reset = 1'b0;
        tick();
        prog_ack  = 1'b1;
        prog_data = mem_word(6'd4);
        tick();
        prog_ack  = 1'b0;
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        check("late_ack_instr", 32'(instr), 32'd0);
        check("late_ack_rd", 32'(prog_rd), 32'd0);

        // Recovery from IDLE.
        run = 1'b1;
        tick();
        run = 1'b0;
        do_fetch(3, 6'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
